// File: rtl/rom_arb_pkg.sv
// Shared types and default widths for the ROM fetch arbiter.
// Optional build macro: ROM_ARB_FIXED_PRIO_EN (fixed-priority arbitration).
package rom_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_LEN_WIDTH  = 8;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rom_arb_pick.sv
// Winner selection: combinational pick plus round-robin pointer register.
// ROM_ARB_FIXED_PRIO_EN selects lowest-index-wins and drops the pointer.
module rom_arb_pick
  import rom_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_take,
  output logic [ID_W-1:0]    o_win,
  output logic               o_any
);

`ifdef ROM_ARB_FIXED_PRIO_EN
  logic w_unused;
  assign w_unused = &{1'b0, clk, rst_n, i_take};

  always_comb begin
    o_win = '0;
    o_any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req[k]) begin
        o_win = ID_W'(k);
        o_any = 1'b1;
      end
    end
  end
`else
  logic [ID_W-1:0] r_ptr;
  int              w_idx;

  // Scan from the pointer downward-last so the closest index to r_ptr wins.
  always_comb begin
    o_win = '0;
    o_any = 1'b0;
    w_idx = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (i_req[w_idx[ID_W-1:0]]) begin
        o_win = ID_W'(w_idx);
        o_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_take && o_any) begin
      r_ptr <= (o_win == ID_W'(NUM_REQ - 1)) ? '0 : o_win + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/rom_fetch_arbiter.sv
// Shares one synchronous-read weight ROM among NUM_REQ burst requesters.
// Optional build macro: ROM_ARB_FIXED_PRIO_EN (see rom_arb_pick).
//
// state    | meaning
// ST_IDLE  | no address issued; arbitrate among req, register grant
// ST_BURST | one address issued per cycle (first one included) until count hits 0
module rom_fetch_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [ADDR_WIDTH-1:0]         rom_a,
  input  logic [DATA_WIDTH-1:0]         rom_q,
  output logic                          rd_valid,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic [id_width(NUM_REQ)-1:0]  rd_id,
  output logic                          rd_last,
  output logic                          busy
);

  localparam int ID_W = id_width(NUM_REQ);

  arb_state_e            r_state;
  arb_state_e            w_state_nxt;
  logic [ID_W-1:0]       w_win;
  logic [ID_W-1:0]       r_owner;
  logic [ID_W-1:0]       r_rd_id;
  logic                  w_any;
  logic                  w_grant;
  logic [ADDR_WIDTH-1:0] r_rom_a;
  logic [ADDR_WIDTH-1:0] w_win_addr;
  logic [LEN_WIDTH-1:0]  r_count;
  logic [LEN_WIDTH-1:0]  w_win_len;
  logic [NUM_REQ-1:0]    r_gnt;
  logic                  r_rd_valid;
  logic                  r_rd_last;

  rom_arb_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_req  (req),
    .i_take (w_grant),
    .o_win  (w_win),
    .o_any  (w_any)
  );

  assign w_grant = (r_state == ST_IDLE) && w_any;

  always_comb begin
    w_win_addr = '0;
    w_win_len  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == ID_W'(i)) begin
        w_win_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_win_len  = req_len[i*LEN_WIDTH +: LEN_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_any) w_state_nxt = ST_BURST;
      ST_BURST: if (r_count == '0) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt      <= '0;
      r_rom_a    <= '0;
      r_count    <= '0;
      r_owner    <= '0;
      r_rd_valid <= 1'b0;
      r_rd_id    <= '0;
      r_rd_last  <= 1'b0;
    end else begin
      r_gnt      <= '0;
      r_rd_valid <= (r_state == ST_BURST);
      r_rd_last  <= (r_state == ST_BURST) && (r_count == '0);
      if (r_state == ST_BURST) r_rd_id <= r_owner;
      if (w_grant) begin
        r_gnt   <= NUM_REQ'(1) << w_win;
        r_rom_a <= w_win_addr;
        r_count <= w_win_len;
        r_owner <= w_win;
      end else if ((r_state == ST_BURST) && (r_count != '0)) begin
        r_rom_a <= r_rom_a + 1'b1;
        r_count <= r_count - 1'b1;
      end
    end
  end

  // rom_q already carries the previous cycle's address, so it passes straight through.
  assign gnt      = r_gnt;
  assign rom_a    = r_rom_a;
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_valid ? rom_q : '0;
  assign rd_id    = r_rd_id;
  assign rd_last  = r_rd_last;
  assign busy     = (r_state == ST_BURST) | r_rd_valid;

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Randomized bench for rom_fetch_arbiter against a queue-based burst model.
// Honors ROM_ARB_FIXED_PRIO_EN the same way the design does.
module tb_rom_fetch_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int LW = 8;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic [N*LW-1:0] req_len;
  logic [N-1:0]    gnt;
  logic [AW-1:0]   rom_a;
  logic [DW-1:0]   rom_q;
  logic            rd_valid;
  logic [DW-1:0]   rd_data;
  logic [IW-1:0]   rd_id;
  logic            rd_last;
  logic            busy;

  rom_fetch_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_len(req_len),
    .gnt(gnt), .rom_a(rom_a), .rom_q(rom_q), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_id(rd_id), .rd_last(rd_last), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC35A;
  endfunction

  always @(posedge clk) rom_q <= rom_f(rom_a);

  typedef struct {
    logic [AW-1:0] a;
    int            id;
    bit            last;
  } iss_t;

  // model: planned issue slots, current slot, word expected on the read port
  iss_t          plan_q[$];
  iss_t          cur;
  iss_t          rd_exp;
  bit            cur_v;
  bit            rdv_exp;
  bit            gnt_exp_v;
  int            gnt_exp_id;
  logic [AW-1:0] last_a;
  int            ptr;

  // requesters
  bit            pend[N];
  logic [AW-1:0] p_addr[N];
  int            p_len[N];
  bit            rand_en;
  bit            hold_mode;

  int cyc;
  int rd_cnt;
  int obs_gnt_id;
  int n_chk;
  int n_pass;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req[i]                = pend[i];
      req_addr[i*AW +: AW]  = p_addr[i];
      req_len[i*LW +: LW]   = LW'(p_len[i]);
    end
  endtask

  function automatic int pick();
    int base;
`ifdef ROM_ARB_FIXED_PRIO_EN
    base = 0;
`else
    base = ptr;
`endif
    for (int k = 0; k < N; k++) begin
      int i;
      i = (base + k) % N;
      if (pend[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    plan_q.delete();
    cur_v     = 0;
    rdv_exp   = 0;
    gnt_exp_v = 0;
    last_a    = '0;
    ptr       = 0;
  endtask

  // Decide what the next cycle looks like from the requests just driven.
  task automatic plan();
    bit was_issuing;
    int w;
    was_issuing = cur_v;
    if (cur_v) last_a = cur.a;
    rdv_exp   = cur_v;
    rd_exp    = cur;
    gnt_exp_v = 0;
    cur_v     = 0;
    if (plan_q.size() != 0) begin
      cur   = plan_q.pop_front();
      cur_v = 1;
    end else if (!was_issuing) begin
      w = pick();
      if (w >= 0) begin
        gnt_exp_v  = 1;
        gnt_exp_id = w;
        ptr        = (w + 1) % N;
        for (int j = 0; j <= p_len[w]; j++)
          plan_q.push_back('{a: AW'(p_addr[w] + j), id: w, last: (j == p_len[w])});
        cur   = plan_q.pop_front();
        cur_v = 1;
      end
    end
  endtask

  task automatic stim();
    for (int i = 0; i < N; i++) begin
      if (gnt[i] && !hold_mode) begin
        pend[i] = 0;
      end else if (rand_en) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i]   = 1;
          p_addr[i] = AW'($urandom);
          p_len[i]  = $urandom_range(0, 5);
        end else if (pend[i] && !gnt[i] && $urandom_range(0, 15) == 0) begin
          pend[i] = 0;
        end
      end
    end
    drive();
  endtask

  task automatic tick();
    logic [31:0] eg;
    @(negedge clk);
    cyc++;
    eg = gnt_exp_v ? (32'd1 << gnt_exp_id) : 32'd0;
    chk("gnt", 32'(gnt), eg);
    chk("rom_a", 32'(rom_a), 32'(cur_v ? cur.a : last_a));
    chk("rd_valid", 32'(rd_valid), 32'(rdv_exp));
    if (rdv_exp) begin
      chk("rd_data", 32'(rd_data), 32'(rom_f(rd_exp.a)));
      chk("rd_id", 32'(rd_id), 32'(rd_exp.id));
      chk("rd_last", 32'(rd_last), 32'(rd_exp.last));
    end
    chk("busy", 32'(busy), 32'(cur_v | rdv_exp));
    obs_gnt_id = -1;
    for (int i = 0; i < N; i++) if (gnt[i]) obs_gnt_id = i;
    if (rd_valid) rd_cnt++;
    stim();
    plan();
  endtask

  task automatic wait_gnt(output int id);
    id = -1;
    for (int t = 0; t < 60 && id < 0; t++) begin
      tick();
      id = obs_gnt_id;
    end
    if (id < 0) chk("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 32'd0);
    chk({tag, "_rom_a"}, 32'(rom_a), 32'd0);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    chk({tag, "_rd_id"}, 32'(rd_id), 32'd0);
    chk({tag, "_rd_last"}, 32'(rd_last), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic clear_pend();
    for (int i = 0; i < N; i++) pend[i] = 0;
  endtask

  initial begin
    int id;
    int ids[5];
    int at[5];
    int exp_seq[5];
    n_chk = 0; n_pass = 0; cyc = 0; rd_cnt = 0; obs_gnt_id = -1;
    rand_en = 0; hold_mode = 0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 0; p_addr[i] = '0; p_len[i] = 0;
    end
    rst_n = 1'b0;
    drive();
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    drive();
    plan();

    // contention with all requests held, single-word bursts
`ifdef ROM_ARB_FIXED_PRIO_EN
    exp_seq = '{1, 1, 1, 1, 1};
    pend[1] = 1; p_addr[1] = 16'h0010; p_len[1] = 0;
    pend[3] = 1; p_addr[3] = 16'h0030; p_len[3] = 0;
`else
    exp_seq = '{0, 1, 2, 3, 0};
    for (int i = 0; i < N; i++) begin
      pend[i] = 1; p_addr[i] = AW'(i * 16); p_len[i] = 0;
    end
`endif
    hold_mode = 1;
    for (int g = 0; g < 5; g++) begin
      wait_gnt(id);
      ids[g] = id;
      at[g]  = cyc;
    end
    for (int g = 0; g < 5; g++) begin
      chk("arb_order", 32'(ids[g]), 32'(exp_seq[g]));
      if (g > 0) chk("arb_gap", 32'(at[g] - at[g-1]), 32'd2);
    end
    hold_mode = 0;
    clear_pend();
    repeat (6) tick();

    // single four-word burst
    pend[2] = 1; p_addr[2] = 16'h0100; p_len[2] = 3;
    rd_cnt = 0;
    wait_gnt(id);
    chk("single_id", 32'(id), 32'd2);
    repeat (6) tick();
    chk("single_words", 32'(rd_cnt), 32'd4);
    chk("single_hold", 32'(rom_a), 32'h0103);

    // address wrap
    pend[1] = 1; p_addr[1] = 16'hFFFE; p_len[1] = 2;
    wait_gnt(id);
    chk("wrap_a0", 32'(rom_a), 32'hFFFE);
    tick();
    chk("wrap_a1", 32'(rom_a), 32'hFFFF);
    tick();
    chk("wrap_a2", 32'(rom_a), 32'h0000);
    repeat (6) tick();

    // randomized traffic
    rand_en = 1;
    repeat (400) tick();
    rand_en = 0;
    clear_pend();
    repeat (12) tick();

    // reset in the middle of an eight-word burst
    pend[2] = 1; p_addr[2] = 16'h2000; p_len[2] = 7;
    wait_gnt(id);
    chk("rst_burst_id", 32'(id), 32'd2);
    repeat (2) tick();
    pend[0] = 1; p_addr[0] = 16'h0040; p_len[0] = 1;
    pend[3] = 1; p_addr[3] = 16'h0300; p_len[3] = 0;
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive();
    plan();
    wait_gnt(id);
    chk("post_rst_first", 32'(id), 32'd0);
    repeat (10) tick();

    rand_en = 1;
    repeat (300) tick();
    rand_en = 0;
    clear_pend();
    repeat (12) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rom_fetch_arbiter.md
ROM_FETCH_ARBITER -- requirements
Module: rom_fetch_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one weight ROM.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, ROM address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 16, ROM word width.
REQ-004 SHALL have parameter LEN_WIDTH, default 8, burst length field width.
REQ-005 SHALL have a single clock and an asynchronous, active-low reset: clk  in  1  clock, all logic on rising edge.
REQ-006 SHALL have rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have req  in  NUM_REQ  per-requester burst request, held until granted.
REQ-008 SHALL have req_addr  in  NUM_REQ*ADDR_WIDTH  per-requester start address, slice i for requester i.
REQ-009 SHALL have req_len  in  NUM_REQ*LEN_WIDTH  per-requester burst length minus one.
REQ-010 SHALL have gnt  out  NUM_REQ  one-hot, one-cycle acceptance pulse.
REQ-011 SHALL have rom_a  out  ADDR_WIDTH  address to the synchronous-read ROM.
REQ-012 SHALL have rom_q  in  DATA_WIDTH  ROM read data, valid one cycle after rom_a.
REQ-013 SHALL have rd_valid / rd_data / rd_id / rd_last  out  1 / DATA_WIDTH / clog2(NUM_REQ) / 1  returned word, owner, last-of-burst flag.
REQ-014 SHALL have busy  out  1  high while a burst is issuing or a word is in flight.

Function
REQ-015 SHALL implement FSM states IDLE and BURST.
REQ-016 In IDLE with any req high, SHALL select one winner, pulse gnt[winner], drive rom_a=req_addr[winner], latch remaining count=req_len[winner] that same cycle.
REQ-017 A burst SHALL issue exactly req_len+1 consecutive addresses, one per cycle, no gaps; req_len=0 means one word.
REQ-018 IDLE->BURST when latched count>0; BURST decrements each cycle; BURST->IDLE after the cycle issuing the last address.
REQ-019 Arbitration SHALL occur only in IDLE; one idle cycle minimum between bursts.
REQ-020 Round-robin: pointer resets to 0; search starts at pointer; after grant to i, pointer=(i+1) mod NUM_REQ.
REQ-021 Address increment SHALL wrap modulo 2^ADDR_WIDTH (0xFFFF -> 0x0000).
REQ-022 rd_valid SHALL assert exactly one cycle after each issued address, with rd_data=rom_q, rd_id=owner, rd_last high on the final word only.
REQ-023 Requests changing while not granted SHALL be sampled fresh each IDLE cycle; req deasserted before grant is dropped silently.
REQ-024 rom_a SHALL hold its last value when not issuing.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, gnt=0, rom_a=0, rd_valid=0, rd_data=0, rd_id=0, rd_last=0, busy=0, pointer=0, count=0.
REQ-026 Reset mid-burst SHALL abandon the burst; no rd_valid for its in-flight word after reset release.

Configuration
REQ-027 With ROM_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority (lowest index wins, pointer unused); without it, round-robin per REQ-020.

Structure
REQ-028 Package rom_arb_pkg SHALL hold the state enum and default width constants.
REQ-029 Winner selection SHALL be a sub-module rom_arb_pick (combinational pick plus pointer register).

Verification
REQ-030 Single: req[2]=1, addr=0x0100, len=3 -> gnt[2] one cycle, rom_a 0x0100..0x0103 consecutive, four rd_valid with rd_id=2, rd_last on 0x0103's word.
REQ-031 Contention: req=4'b1111, all len=0, held -> grant order 0,1,2,3,0 with one idle cycle between grants.
REQ-032 Wrap: addr=0xFFFE, len=2 -> rom_a 0xFFFE, 0xFFFF, 0x0000.
REQ-033 Reset mid-burst: len=7, rst_n low after 3 addresses -> all outputs 0 immediately, no further rd_valid, next grant goes to requester 0 first.
REQ-034 Fixed priority (macro defined): req=4'b1010 held -> requester 1 granted every arbitration.
